uart_byte_rx: RTL and testbench

- Serial UART receiver that sits directly upstream of the 8-bit command input of the BLDC commutation top level.
- Converts the asynchronous 8N1 line from the host transmitter into a held parallel byte plus a one-cycle strobe.
- The held byte drives the command splitter continuously; the byte changes only on a correctly framed reception.

---
 rtl/uart_rx_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 42 ++++
 rtl/uart_byte_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART byte receiver.
// UART_RX_PARITY_EN adds the PARITY state (8E1 framing instead of 8N1).
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator with restart for start-edge alignment.
// Identical for both framings (UART_RX_PARITY_EN has no effect here).
module uart_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_check
        $error("uart_baud_tick: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 1");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == CNT_W'(DIV - 1))) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_W'(DIV - 1));

endmodule

// File: rtl/uart_byte_rx.sv
// UART receiver: 8N1 serial line to held byte plus valid/frame_err strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity check before the stop bit.
module uart_byte_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);

    if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
        $error("uart_byte_rx: OVERSAMPLE must be even and at least 4");
    end

    logic                 rx_meta_q, rxs_q;
    logic                 tick, restart_c, frame_ok_c;
    rx_state_t            state_q, state_d;
    logic [SCNT_W-1:0]    scnt_q, scnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_q, par_err_d;
`endif

    uart_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart_c),
        .tick   (tick)
    );

    // Next-state, datapath and strobe logic.
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        restart_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d  = par_err_q;
        frame_ok_c = rxs_q && !par_err_q;
`else
        frame_ok_c = rxs_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d   = START;
                    scnt_d    = '0;
                    restart_c = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (scnt_q == SCNT_W'(OVERSAMPLE / 2 - 1)) begin
                        scnt_d = '0;
                        idx_d  = '0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (scnt_q == SCNT_W'(OVERSAMPLE - 1)) begin
                        scnt_d  = '0;
                        shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (scnt_q == SCNT_W'(OVERSAMPLE - 1)) begin
                        scnt_d    = '0;
                        par_err_d = (^shift_q) ^ rxs_q;
                        state_d   = STOP;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (scnt_q == SCNT_W'(OVERSAMPLE - 1)) begin
                        scnt_d = '0;
                        if (frame_ok_c) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
            // A held-low line (break) must return high before a new start is accepted.
            WAIT_IDLE: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            scnt_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at default parameters (432 clk per bit).
// Define UART_RX_PARITY_EN to exercise 8E1 framing and the parity checks.
module tb_uart_byte_rx;

    localparam int unsigned BIT_CLKS = 16 * 27;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    int         n_ferr   = 0;
    logic       both_seen = 1'b0;
    logic [7:0] hist[$];

    always #10 clk = ~clk;

    uart_byte_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                n_valid++;
                hist.push_back(data);
            end
            if (frame_err) n_ferr++;
            if (valid && frame_err) both_seen = 1'b1;
        end
    end

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    // Start bit, 8 data bits LSB first, optional parity, stop; line left at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        logic [10:0] f;
`ifdef UART_RX_PARITY_EN
        f = {stop, par, b, 1'b0};
`else
        f = {par, stop, b, 1'b0};
`endif
        for (int i = 0; i < NBITS; i++) send_bit(f[i]);
    endtask

    initial begin
        int v0, f0, h0;
        logic [7:0] b55;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vecs[2] = '{8'hC3, 1'b0, 0, 1, 8'h5A};
        vecs[3] = '{8'h12, 1'b1, 1, 0, 8'h12};

        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(3);
        check("reset data", 32'(data), 32'h00);
        check("reset valid", 32'(valid), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset busy", 32'(busy), 0);
        rst_n = 1'b1;
        wait_clks(4);

        // Short low glitch while idle: rejected at mid start bit.
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        wait_clks(40);
        check("glitch busy during", 32'(busy), 1);
        wait_clks(BIT_CLKS * 3 / 16 - 40);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("glitch valid", 32'(n_valid - v0), 0);
        check("glitch frame_err", 32'(n_ferr - f0), 0);
        check("glitch busy after", 32'(busy), 0);
        check("glitch data", 32'(data), 32'h00);

        for (int i = 0; i < 4; i++) begin
            v0 = n_valid; f0 = n_ferr;
            send_frame(vecs[i].byte_v, ^vecs[i].byte_v, vecs[i].stop_v);
            rx = 1'b1;
            wait_clks(BIT_CLKS);
            check($sformatf("vec%0d valid", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d frame_err", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d data", i), 32'(data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d busy", i), 32'(busy), 0);
        end

        // Back-to-back frames, no idle gap.
        v0 = n_valid; h0 = hist.size();
        send_frame(8'h3C, ^8'h3C, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        wait_clks(BIT_CLKS);
        check("b2b valid count", 32'(n_valid - v0), 2);
        check("b2b first", (hist.size() > h0) ? 32'(hist[h0]) : 32'hDEAD, 32'h3C);
        check("b2b second", (hist.size() > h0 + 1) ? 32'(hist[h0 + 1]) : 32'hDEAD, 32'hFF);

        // Bad stop followed by a long break, then a good frame.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h81, ^8'h81, 1'b0);
        wait_clks(BIT_CLKS * 20);
        check("break frame_err", 32'(n_ferr - f0), 1);
        check("break valid", 32'(n_valid - v0), 0);
        check("break busy", 32'(busy), 1);
        check("break data held", 32'(data), 32'hFF);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        send_frame(8'h12, ^8'h12, 1'b1);
        wait_clks(BIT_CLKS);
        check("after break valid", 32'(n_valid - v0), 1);
        check("after break data", 32'(data), 32'h12);
        check("after break frame_err", 32'(n_ferr - f0), 1);

        // Reset asserted in the middle of bit 4.
        b55 = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b55[i]);
        rx = b55[4];
        wait_clks(BIT_CLKS / 2);
        rst_n = 1'b0;
        #1;
        check("midreset data", 32'(data), 32'h00);
        check("midreset busy", 32'(busy), 0);
        rx = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(BIT_CLKS * 2);
        v0 = n_valid;
        send_frame(8'h0F, ^8'h0F, 1'b1);
        wait_clks(BIT_CLKS);
        check("postreset valid", 32'(n_valid - v0), 1);
        check("postreset data", 32'(data), 32'h0F);

`ifdef UART_RX_PARITY_EN
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("parity bad frame_err", 32'(n_ferr - f0), 1);
        check("parity bad valid", 32'(n_valid - v0), 0);
        check("parity bad data held", 32'(data), 32'h0F);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(BIT_CLKS);
        check("parity good valid", 32'(n_valid - v0), 1);
        check("parity good data", 32'(data), 32'h07);
`endif

        check("valid with frame_err", 32'(both_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
